pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_seq_unit_if.sv | 28 ++
 rtl/pc_seq_unit.sv | 127 ++++++++++++
 tb/tb_pc_seq_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_unit_if.sv
// Bus bundle between the instruction-fetch control and the PC sequencer.
// Control inputs flow from the master; PC state and status flow back from the slave.
interface pc_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [2:0]       pc_src;
    logic             branch_taken;
    logic [WIDTH-1:0] con_ba;
    logic [WIDTH-7:0] jt;
    logic [WIDTH-1:0] databus_a;
    logic             irq;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             kernel_d;
    logic             irq_ack;
    logic             ras_empty;

    modport master (
        output stall, pc_src, branch_taken, con_ba, jt, databus_a, irq,
        input  pc, pc_plus4, kernel_d, irq_ack, ras_empty
    );

    modport slave (
        input  stall, pc_src, branch_taken, con_ba, jt, databus_a, irq,
        output pc, pc_plus4, kernel_d, irq_ack, ras_empty
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC selection, kernel/user protection,
// interrupt latching and a small circular return-address stack.
module pc_seq_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h80000000,
    parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h80000004,
    parameter logic [WIDTH-1:0] XADR_VEC  = 32'h80000008,
    parameter int               RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_seq_unit_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    typedef enum logic [2:0] {
        SRC_INCR   = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_JR     = 3'd3,
        SRC_ILLOP  = 3'd4,
        SRC_XADR   = 3'd5,
        SRC_JAL    = 3'd6,
        SRC_RET    = 3'd7
    } pc_src_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kernel_q;
    logic             irq_pend_q, irq_pend_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] incr_pc;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] top_entry;
    logic [PW-1:0]    top_idx;
    logic             user_mode;
    logic             push;
    logic             take_irq;
    pc_src_e          src;

    // The kernel bit is carried through unchanged so sequential code never crosses privilege.
    assign incr_pc   = {pc_q[WIDTH-1], pc_q[WIDTH-2:0] + (WIDTH-1)'(4)};
    assign jump_tgt  = {pc_q[WIDTH-1:WIDTH-4], bus.jt, 2'b00};
    assign top_idx   = ptr_q - 1'b1;
    assign top_entry = ras_q[top_idx];
    assign user_mode = ~pc_q[WIDTH-1];
    assign src       = pc_src_e'(bus.pc_src);

    always_comb begin
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        take_irq   = 1'b0;
        irq_pend_d = irq_pend_q | (bus.irq & user_mode);

        if (!bus.stall) begin
            if (src == SRC_ILLOP) begin
                pc_d = ILLOP_VEC;
            end else if (irq_pend_q) begin
                pc_d       = XADR_VEC;
                take_irq   = 1'b1;
                irq_pend_d = 1'b0;
            end else begin
                case (src)
                    SRC_INCR:   pc_d = incr_pc;
                    SRC_BRANCH: pc_d = bus.branch_taken ? bus.con_ba : incr_pc;
                    SRC_JUMP:   pc_d = jump_tgt;
                    SRC_JR: begin
                        pc_d = bus.databus_a;
                        if (user_mode) pc_d[WIDTH-1] = 1'b0;
                    end
                    SRC_XADR:   pc_d = XADR_VEC;
                    SRC_JAL: begin
                        pc_d  = jump_tgt;
                        push  = 1'b1;
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
                    end
                    SRC_RET: begin
                        if (cnt_q != '0) begin
                            pc_d  = top_entry;
                            ptr_d = top_idx;
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            pc_d = bus.databus_a;
                        end
                        if (user_mode) pc_d[WIDTH-1] = 1'b0;
                    end
                    default:    pc_d = incr_pc;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_VEC;
            kernel_q   <= 1'b1;
            irq_pend_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            kernel_q   <= pc_q[WIDTH-1];
            irq_pend_q <= irq_pend_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Writing at the pointer on a full stack naturally overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            ras_q[ptr_q] <= incr_pc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = incr_pc;
    assign bus.kernel_d  = kernel_q;
    assign bus.irq_ack   = take_irq & reset;
    assign bus.ras_empty = (cnt_q == '0);
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: vector table plus hand-written multi-cycle sequences.
module tb_pc_seq_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_seq_unit_if #(.WIDTH(32)) bus ();

    pc_seq_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  src;
        logic        bt;
        logic [31:0] conBa;
        logic [25:0] jt;
        logic [31:0] dbA;
        logic        irq;
        logic [31:0] expPc;
        logic        expKd;
        logic        expAck;
        logic        expEmpty;
    } vec_t;

    vec_t vecs[17];
    logic ackSeen;

    function automatic vec_t makeVec(input logic rst, input logic stall, input logic [2:0] src,
                                     input logic bt, input logic [31:0] conBa, input logic [25:0] jt,
                                     input logic [31:0] dbA, input logic irq, input logic [31:0] expPc,
                                     input logic expKd, input logic expAck, input logic expEmpty);
        vec_t v;
        v.rst = rst; v.stall = stall; v.src = src; v.bt = bt; v.conBa = conBa; v.jt = jt;
        v.dbA = dbA; v.irq = irq; v.expPc = expPc; v.expKd = expKd; v.expAck = expAck;
        v.expEmpty = expEmpty;
        return v;
    endfunction

    function automatic logic [31:0] incrModel(input logic [31:0] p);
        logic [30:0] low;
        low = p[30:0] + 31'd4;
        return {p[31], low};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs, capture the combinational ack before the edge, then step one clock.
    task automatic applyStimulus(input logic rst, input logic stall, input logic [2:0] src,
                                 input logic bt, input logic [31:0] conBa, input logic [25:0] jt,
                                 input logic [31:0] dbA, input logic irq, output logic ack);
        reset            = rst;
        bus.stall        = stall;
        bus.pc_src       = src;
        bus.branch_taken = bt;
        bus.con_ba       = conBa;
        bus.jt           = jt;
        bus.databus_a    = dbA;
        bus.irq          = irq;
        #1;
        ack = bus.irq_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic stall, input logic [2:0] src, input logic [25:0] jt,
                        input logic [31:0] dbA, input logic irq);
        applyStimulus(1'b1, stall, src, 1'b0, 32'h0, jt, dbA, irq, ackSeen);
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, ackSeen);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, ackSeen);
    endtask

    initial begin
        int ackCount;
        checks = 0;
        errors = 0;

        vecs[0]  = makeVec(0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000000, 1, 0, 1);
        vecs[1]  = makeVec(0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000000, 1, 0, 1);
        vecs[2]  = makeVec(1, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000004, 1, 0, 1);
        vecs[3]  = makeVec(1, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000008, 1, 0, 1);
        vecs[4]  = makeVec(1, 0, 3'd1, 0, 32'h12345678, 26'h0,       32'h0,        0, 32'h8000000C, 1, 0, 1);
        vecs[5]  = makeVec(1, 0, 3'd1, 1, 32'h80000100, 26'h0,       32'h0,        0, 32'h80000100, 1, 0, 1);
        vecs[6]  = makeVec(1, 0, 3'd2, 0, 32'h0,        26'h0123456, 32'h0,        0, 32'h8048D158, 1, 0, 1);
        vecs[7]  = makeVec(1, 0, 3'd5, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000008, 1, 0, 1);
        vecs[8]  = makeVec(1, 0, 3'd3, 0, 32'h0,        26'h0,       32'h00400000, 0, 32'h00400000, 1, 0, 1);
        vecs[9]  = makeVec(1, 0, 3'd3, 0, 32'h0,        26'h0,       32'h80001000, 0, 32'h00001000, 0, 0, 1);
        vecs[10] = makeVec(1, 0, 3'd7, 0, 32'h0,        26'h0,       32'h80002000, 0, 32'h00002000, 0, 0, 1);
        vecs[11] = makeVec(1, 0, 3'd6, 0, 32'h0,        26'h0000400, 32'h0,        0, 32'h00001000, 0, 0, 0);
        vecs[12] = makeVec(1, 0, 3'd7, 0, 32'h0,        26'h0,       32'hDEADBEEF, 0, 32'h00002004, 0, 0, 1);
        vecs[13] = makeVec(1, 1, 3'd3, 0, 32'h0,        26'h0,       32'h12340000, 0, 32'h00002004, 0, 0, 1);
        vecs[14] = makeVec(1, 0, 3'd4, 0, 32'h0,        26'h0,       32'h0,        0, 32'h80000004, 0, 0, 1);
        vecs[15] = makeVec(1, 0, 3'd7, 0, 32'h0,        26'h0,       32'h90000000, 0, 32'h90000000, 1, 0, 1);
        vecs[16] = makeVec(1, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 32'h90000004, 1, 0, 1);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].src, vecs[i].bt, vecs[i].conBa,
                          vecs[i].jt, vecs[i].dbA, vecs[i].irq, ackSeen);
            checkOutput($sformatf("vec%0d pc", i), bus.pc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d pc_plus4", i), bus.pc_plus4, incrModel(vecs[i].expPc));
            checkOutput($sformatf("vec%0d kernel_d", i), 32'(bus.kernel_d), 32'(vecs[i].expKd));
            checkOutput($sformatf("vec%0d irq_ack", i), 32'(ackSeen), 32'(vecs[i].expAck));
            checkOutput($sformatf("vec%0d ras_empty", i), 32'(bus.ras_empty), 32'(vecs[i].expEmpty));
        end

        // Stack overflow: five calls through a four-entry stack, then five returns.
        resetDut();
        step(0, 3'd3, 26'h0, 32'h00000100, 0);
        step(0, 3'd6, 26'h0000080, 32'h0, 0);
        step(0, 3'd6, 26'h00000C0, 32'h0, 0);
        step(0, 3'd6, 26'h0000100, 32'h0, 0);
        step(0, 3'd6, 26'h0000140, 32'h0, 0);
        step(0, 3'd6, 26'h0000180, 32'h0, 0);
        checkOutput("ovf after calls pc", bus.pc, 32'h00000600);
        step(0, 3'd7, 26'h0, 32'h0, 0);
        checkOutput("ovf ret1", bus.pc, 32'h00000504);
        step(0, 3'd7, 26'h0, 32'h0, 0);
        checkOutput("ovf ret2", bus.pc, 32'h00000404);
        step(0, 3'd7, 26'h0, 32'h0, 0);
        checkOutput("ovf ret3", bus.pc, 32'h00000304);
        step(0, 3'd7, 26'h0, 32'h0, 0);
        checkOutput("ovf ret4", bus.pc, 32'h00000204);
        checkOutput("ovf empty after ret4", 32'(bus.ras_empty), 32'd1);
        step(0, 3'd7, 26'h0, 32'h80000700, 0);
        checkOutput("ovf ret5 databus", bus.pc, 32'h00000700);
        checkOutput("ovf empty after ret5", 32'(bus.ras_empty), 32'd1);

        // Interrupt arriving while stalled is latched and taken exactly once on release.
        resetDut();
        step(0, 3'd3, 26'h0, 32'h00400010, 0);
        ackCount = 0;
        step(1, 3'd0, 26'h0, 32'h0, 1);
        ackCount += int'(ackSeen);
        checkOutput("stall1 pc", bus.pc, 32'h00400010);
        step(1, 3'd0, 26'h0, 32'h0, 0);
        ackCount += int'(ackSeen);
        checkOutput("stall2 pc", bus.pc, 32'h00400010);
        step(1, 3'd0, 26'h0, 32'h0, 0);
        ackCount += int'(ackSeen);
        checkOutput("stall3 pc", bus.pc, 32'h00400010);
        checkOutput("stall ack", 32'(ackCount), 32'd0);
        step(0, 3'd0, 26'h0, 32'h0, 0);
        ackCount += int'(ackSeen);
        checkOutput("release pc", bus.pc, 32'h80000008);
        step(0, 3'd0, 26'h0, 32'h0, 0);
        ackCount += int'(ackSeen);
        checkOutput("after irq pc", bus.pc, 32'h8000000C);
        checkOutput("irq ack count", 32'(ackCount), 32'd1);

        // Illegal-op outranks a pending interrupt, which is then taken next cycle.
        resetDut();
        step(0, 3'd3, 26'h0, 32'h00400010, 0);
        step(0, 3'd0, 26'h0, 32'h0, 1);
        checkOutput("prio latch pc", bus.pc, 32'h00400014);
        checkOutput("prio latch ack", 32'(ackSeen), 32'd0);
        step(0, 3'd4, 26'h0, 32'h0, 0);
        checkOutput("prio illop pc", bus.pc, 32'h80000004);
        checkOutput("prio illop ack", 32'(ackSeen), 32'd0);
        step(0, 3'd0, 26'h0, 32'h0, 0);
        checkOutput("prio irq pc", bus.pc, 32'h80000008);
        checkOutput("prio irq ack", 32'(ackSeen), 32'd1);

        // Increment wraps within the low field and never flips the kernel bit.
        resetDut();
        step(0, 3'd3, 26'h0, 32'h7FFFFFFC, 0);
        step(0, 3'd0, 26'h0, 32'h0, 0);
        checkOutput("wrap user", bus.pc, 32'h00000000);
        step(0, 3'd4, 26'h0, 32'h0, 0);
        step(0, 3'd3, 26'h0, 32'hFFFFFFFC, 0);
        checkOutput("kernel jr", bus.pc, 32'hFFFFFFFC);
        step(0, 3'd0, 26'h0, 32'h0, 0);
        checkOutput("wrap kernel", bus.pc, 32'h80000000);

        // Reset during a call aborts the push.
        resetDut();
        step(0, 3'd3, 26'h0, 32'h00000100, 0);
        step(0, 3'd6, 26'h0000080, 32'h0, 0);
        checkOutput("midrst push empty", 32'(bus.ras_empty), 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b0, 32'h0, 26'h0000080, 32'h0, 1'b1, ackSeen);
        checkOutput("midrst pc", bus.pc, 32'h80000000);
        checkOutput("midrst empty", 32'(bus.ras_empty), 32'd1);
        checkOutput("midrst kernel_d", 32'(bus.kernel_d), 32'd1);
        step(0, 3'd7, 26'h0, 32'h00000300, 0);
        checkOutput("midrst ret databus", bus.pc, 32'h00000300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
